// File: rtl/adbg_ahb3_burst_seq.sv
// Burst command sequencer in front of the AHB3 BIU: splits one burst command into
// single BIU accesses, streams write/read words and reports a sticky error.
module adbg_ahb3_burst_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  biu_clk,
    input  logic                  biu_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [3:0]            cmd_word_size,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  biu_strb,
    output logic                  biu_rw,
    output logic [ADDR_WIDTH-1:0] biu_addr,
    output logic [3:0]            biu_word_size,
    output logic [DATA_WIDTH-1:0] biu_di,
    input  logic                  biu_rdy,
    input  logic [DATA_WIDTH-1:0] biu_do,
    input  logic                  biu_err
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, RDOUT, FIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw;
    logic [3:0]            size;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  size_ok;
    logic                  cmd_acc;
    logic                  biu_done;
    logic [7:0]            shamt;

    always_comb begin
        case (cmd_word_size)
            4'd1, 4'd2, 4'd4: size_ok = 1'b1;
            4'd8:             size_ok = (DATA_WIDTH == 64);
            default:          size_ok = 1'b0;
        endcase
    end

    assign cmd_acc  = (state == IDLE) && cmd_valid;
    assign biu_done = (state == WAIT) && biu_rdy;
    // The BIU takes the MSB-aligned slice, so right-aligned words move up.
    assign shamt    = 8'(DATA_WIDTH) - {1'b0, size, 3'b000};

    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (!size_ok || cmd_count == '0) state_nxt = FIN;
                    else if (cmd_rw)                 state_nxt = ISSUE;
                    else                             state_nxt = FETCH;
                end
            end
            FETCH: if (wr_valid) state_nxt = ISSUE;
            ISSUE: if (biu_rdy)  state_nxt = WAIT;
            WAIT: begin
                if (biu_rdy) begin
                    if (rw)                              state_nxt = RDOUT;
                    else if (remaining == CNT_WIDTH'(1)) state_nxt = FIN;
                    else                                 state_nxt = FETCH;
                end
            end
            RDOUT: begin
                if (rd_ready) state_nxt = (remaining != '0) ? ISSUE : FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        biu_strb  = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            FETCH:   wr_ready  = 1'b1;
            ISSUE:   biu_strb  = 1'b1;
            RDOUT:   rd_valid  = 1'b1;
            FIN:     done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) begin
            addr      <= '0;
            rw        <= 1'b0;
            size      <= '0;
            remaining <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
            biu_di    <= '0;
            rd_data   <= '0;
        end else begin
            if (cmd_acc) begin
                addr      <= cmd_addr;
                rw        <= cmd_rw;
                size      <= cmd_word_size;
                remaining <= cmd_count;
                err       <= !size_ok;
                err_addr  <= size_ok ? '0 : cmd_addr;
            end
            if (state == FETCH && wr_valid) biu_di <= wr_data << shamt;
            if (biu_done) begin
                // Only the first failing access is recorded; the burst carries on.
                if (biu_err && !err) begin
                    err      <= 1'b1;
                    err_addr <= addr;
                end
                addr      <= addr + {{(ADDR_WIDTH-4){1'b0}}, size};
                remaining <= remaining - CNT_WIDTH'(1);
                if (rw) rd_data <= biu_do;
            end
        end
    end

    assign biu_rw        = rw;
    assign biu_addr      = addr;
    assign biu_word_size = size;

endmodule

// File: tb/tb_adbg_ahb3_burst_seq.sv
// Bench for adbg_ahb3_burst_seq: directed bursts against a queue-based access model
// with a simple latency-programmable BIU responder.
module tb_adbg_ahb3_burst_seq;

    logic        biu_clk = 1'b0;
    logic        biu_rst;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_word_size;
    logic [15:0] cmd_count;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, err;
    logic [31:0] err_addr;
    logic        biu_strb, biu_rw;
    logic [31:0] biu_addr;
    logic [3:0]  biu_word_size;
    logic [31:0] biu_di;
    logic        biu_rdy;
    logic [31:0] biu_do;
    logic        biu_err;

    adbg_ahb3_burst_seq dut (
        .biu_clk(biu_clk), .biu_rst(biu_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_word_size(cmd_word_size), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err), .err_addr(err_addr),
        .biu_strb(biu_strb), .biu_rw(biu_rw), .biu_addr(biu_addr),
        .biu_word_size(biu_word_size), .biu_di(biu_di),
        .biu_rdy(biu_rdy), .biu_do(biu_do), .biu_err(biu_err)
    );

    always #5 biu_clk = ~biu_clk;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  size;
        logic [31:0] di;
    } acc_t;

    int checks = 0;
    int errors = 0;

    acc_t        exp_acc[$];
    logic [31:0] exp_rd[$];
    logic        exp_err;
    logic [31:0] exp_err_addr;
    bit          exp_active = 0;

    logic [31:0] wr_src[8];
    logic [31:0] rsp_do[8];
    bit          rsp_err[8];
    logic [31:0] wr_q[$];
    logic [31:0] do_q[$];
    bit          err_q[$];

    int biu_lat = 0;
    int biu_phase = 0, biu_cnt = 0, biu_idx = 0;
    int acc_cnt = 0, stall_left = 0, stalls_seen = 0, cyc = 0, done_cyc = 0;
    bit done_seen = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_di[$];
    logic [3:0]  log_size[$];
    logic [31:0] rd_log[$];
    int          rd_acc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial forever @(posedge biu_clk) cyc++;

    // BIU responder: accepts a strobe while rdy is high, drops rdy on the accept
    // edge, then completes after biu_lat cycles (or a varying 1..3 when zero).
    initial forever begin
        @(negedge biu_clk);
        if (biu_rst) begin
            biu_rdy = 1'b1; biu_err = 1'b0; biu_do = '0; biu_phase = 0;
        end else begin
            case (biu_phase)
                0: if (biu_strb) biu_phase = 1;
                1: begin
                    biu_rdy = 1'b0;
                    biu_cnt = (biu_lat > 0) ? biu_lat : 1 + (biu_idx % 3);
                    biu_idx++;
                    biu_phase = 2;
                end
                default: begin
                    if (biu_cnt > 1) biu_cnt--;
                    else begin
                        biu_rdy   = 1'b1;
                        biu_do    = (do_q.size() != 0) ? do_q.pop_front() : 32'hDEAD_0000;
                        biu_err   = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
                        biu_phase = 0;
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(negedge biu_clk);
        if (biu_rst) wr_valid = 1'b0;
        else begin
            wr_valid = (wr_q.size() != 0);
            if (wr_valid) wr_data = wr_q[0];
            if (wr_valid && wr_ready) void'(wr_q.pop_front());
        end
    end

    initial forever begin
        @(negedge biu_clk);
        if (rd_valid && stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
            stalls_seen++;
        end else rd_ready = 1'b1;
    end

    // Compare process: every access, read word and completion against the model.
    initial begin : cmp
        acc_t e;
        forever begin
            @(negedge biu_clk);
            #1;
            if (!biu_rst) begin
                if (biu_strb && biu_rdy) begin
                    acc_cnt++;
                    log_addr.push_back(biu_addr);
                    log_di.push_back(biu_di);
                    log_size.push_back(biu_word_size);
                    chk("strobe_expected", exp_acc.size() != 0, 1);
                    if (exp_acc.size() != 0) begin
                        e = exp_acc.pop_front();
                        chk("biu_addr", biu_addr, e.addr);
                        chk("biu_rw", biu_rw, e.rw);
                        chk("biu_word_size", biu_word_size, e.size);
                        if (!e.rw) chk("biu_di", biu_di, e.di);
                    end
                end
                if (rd_valid) begin
                    chk("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd[0]);
                    chk("strobe_during_rdout", biu_strb, 0);
                    if (rd_ready) begin
                        rd_log.push_back(rd_data);
                        rd_acc.push_back(acc_cnt);
                        if (exp_rd.size() != 0) void'(exp_rd.pop_front());
                    end
                end
                if (done) begin
                    chk("done_expected", exp_active, 1);
                    if (exp_active) begin
                        chk("err", err, exp_err);
                        chk("err_addr", err_addr, exp_err_addr);
                        chk("pending_accesses", exp_acc.size() + exp_rd.size(), 0);
                    end
                    exp_active = 0;
                    done_seen  = 1;
                    done_cyc   = cyc;
                end
            end
        end
    end

    task automatic start_cmd(input logic [31:0] a, input logic r, input logic [3:0] sz,
                             input logic [15:0] n, output int c0);
        acc_t e;
        exp_err = 1'b0;
        exp_err_addr = '0;
        if (!(sz == 4'd1 || sz == 4'd2 || sz == 4'd4)) begin
            exp_err = 1'b1;
            exp_err_addr = a;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                e.addr = a + 32'(i) * 32'(sz);
                e.rw   = r;
                e.size = sz;
                e.di   = wr_src[i] << (32 - 8 * int'(sz));
                exp_acc.push_back(e);
                if (r) exp_rd.push_back(rsp_do[i]);
                else   wr_q.push_back(wr_src[i]);
                do_q.push_back(rsp_do[i]);
                err_q.push_back(rsp_err[i]);
                if (rsp_err[i] && !exp_err) begin
                    exp_err = 1'b1;
                    exp_err_addr = e.addr;
                end
            end
        end
        log_addr.delete(); log_di.delete(); log_size.delete();
        rd_log.delete(); rd_acc.delete();
        acc_cnt = 0;
        done_seen = 0;
        exp_active = 1;
        @(negedge biu_clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_rw = r; cmd_word_size = sz; cmd_count = n;
        c0 = cyc;
        @(negedge biu_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int n_exp, input int c0, output int lat);
        for (int i = 0; i < 500 && !done_seen; i++) @(negedge biu_clk);
        #2;
        chk("done_timeout", done_seen, 1);
        chk("access_count", acc_cnt, n_exp);
        lat = done_cyc - c0;
    endtask

    int c0, lat;

    initial begin
        biu_rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_word_size = '0; cmd_count = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        biu_rdy = 1'b1; biu_do = '0; biu_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_src[i] = '0; rsp_do[i] = '0; rsp_err[i] = 0;
        end
        repeat (3) @(negedge biu_clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", {err, err_addr}, 0);
        chk("rst_biu_strb", biu_strb, 0);
        chk("rst_biu_attr", {biu_rw, biu_addr, biu_word_size}, 0);
        chk("rst_biu_di", biu_di, 0);
        biu_rst = 1'b0;
        repeat (2) @(negedge biu_clk);

        // Word write burst
        wr_src[0] = 32'hA; wr_src[1] = 32'hB; wr_src[2] = 32'hC;
        start_cmd(32'h1000, 1'b0, 4'd4, 16'd3, c0);
        finish_cmd(3, c0, lat);
        chk("wb_addr0", log_addr[0], 32'h1000);
        chk("wb_addr2", log_addr[2], 32'h1008);
        chk("wb_di1", log_di[1], 32'hB);
        chk("wb_err", err, 0);

        // Byte write lands in the top byte lane
        wr_src[0] = 32'h5A;
        start_cmd(32'h2003, 1'b0, 4'd1, 16'd1, c0);
        finish_cmd(1, c0, lat);
        chk("byte_di", log_di[0], 32'h5A00_0000);
        chk("byte_size", log_size[0], 1);
        chk("byte_addr", log_addr[0], 32'h2003);

        // Halfword read burst with a stalled sink
        rsp_do[0] = 32'h1234; rsp_do[1] = 32'hBEEF;
        stall_left = 5; stalls_seen = 0;
        start_cmd(32'h0400, 1'b1, 4'd2, 16'd2, c0);
        finish_cmd(2, c0, lat);
        chk("rd_word0", rd_log[0], 32'h1234);
        chk("rd_word1", rd_log[1], 32'hBEEF);
        chk("rd_serial", rd_acc[0], 1);
        chk("rd_stalls", stalls_seen, 5);
        chk("rd_addr1", log_addr[1], 32'h0402);

        // Errors on accesses 2 and 4 do not stop the burst
        for (int i = 0; i < 4; i++) wr_src[i] = 32'h100 + 32'(i);
        rsp_err[1] = 1; rsp_err[3] = 1;
        start_cmd(32'h0, 1'b0, 4'd4, 16'd4, c0);
        finish_cmd(4, c0, lat);
        chk("errb_err", err, 1);
        chk("errb_err_addr", err_addr, 32'h4);
        rsp_err[1] = 0; rsp_err[3] = 0;

        // Zero count: done straight after accept, err cleared from previous command
        start_cmd(32'h0500, 1'b0, 4'd4, 16'd0, c0);
        finish_cmd(0, c0, lat);
        chk("cnt0_latency", lat, 1);
        chk("cnt0_err", err, 0);

        // Illegal size
        start_cmd(32'h0600, 1'b0, 4'd3, 16'd2, c0);
        finish_cmd(0, c0, lat);
        chk("size3_latency", lat, 1);
        chk("size3_err", {err, err_addr}, {1'b1, 32'h0600});

        // Address wrap
        wr_src[0] = 32'h11; wr_src[1] = 32'h22;
        start_cmd(32'hFFFF_FFFC, 1'b0, 4'd4, 16'd2, c0);
        finish_cmd(2, c0, lat);
        chk("wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", log_addr[1], 32'h0);
        chk("wrap_err", err, 0);

        // Byte read with error on the first access
        rsp_do[0] = 32'h81; rsp_do[1] = 32'h7E; rsp_do[2] = 32'h3C; rsp_err[0] = 1;
        start_cmd(32'h0700, 1'b1, 4'd1, 16'd3, c0);
        finish_cmd(3, c0, lat);
        chk("rderr_word2", rd_log[2], 32'h3C);
        chk("rderr_err_addr", {err, err_addr}, {1'b1, 32'h0700});
        rsp_err[0] = 0;

        // Reset while an access is outstanding
        biu_lat = 6;
        wr_src[0] = 32'hCAFE_F00D; wr_src[1] = 32'h1; wr_src[2] = 32'h2;
        start_cmd(32'h3000, 1'b0, 4'd4, 16'd3, c0);
        for (int i = 0; i < 50 && biu_phase != 2; i++) @(negedge biu_clk);
        chk("reached_wait", biu_phase, 2);
        biu_rst = 1'b1;
        exp_active = 0;
        exp_acc.delete(); exp_rd.delete(); wr_q.delete(); do_q.delete(); err_q.delete();
        #1;
        chk("wrst_cmd_ready", cmd_ready, 1);
        chk("wrst_strb_done", {biu_strb, done, wr_ready, rd_valid}, 0);
        chk("wrst_biu_di", biu_di, 0);
        chk("wrst_biu_addr", biu_addr, 0);
        chk("wrst_err", {err, err_addr}, 0);
        done_seen = 0;
        repeat (2) @(negedge biu_clk);
        biu_rst = 1'b0;
        repeat (6) @(negedge biu_clk);
        #2;
        chk("wrst_no_done", done_seen, 0);
        chk("wrst_idle", cmd_ready, 1);

        // Recovery after reset
        biu_lat = 0;
        wr_src[0] = 32'h55AA;
        start_cmd(32'h0800, 1'b0, 4'd4, 16'd1, c0);
        finish_cmd(1, c0, lat);
        chk("recover_di", log_di[0], 32'h55AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adbg_ahb3_burst_seq.md
Name: adbg_ahb3_burst_seq

Overview:
- Command sequencer directly upstream of the AHB3 bus interface unit, in the debug (biu_clk) domain.
- Accepts one burst command (start address, word size, word count, direction) and breaks it into single BIU accesses with auto-incrementing address.
- Streams write data in and read data out over valid/ready handshakes.
- Reports completion with a sticky error flag and the address of the first failing access.

Parameters:
- ADDR_WIDTH, 32, address width; matches the BIU.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- CNT_WIDTH, 16, width of the word-count field.

Ports:
- biu_clk  in  1  clock; the only clock.
- biu_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_rw  in  1  1 = read, 0 = write (same encoding as biu_rw).
- cmd_word_size  in  4  bytes per access: 1, 2, 4, or 8 (8 only when DATA_WIDTH = 64).
- cmd_count  in  CNT_WIDTH  number of accesses.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write word taken.
- wr_data  in  DATA_WIDTH  write word, right-aligned.
- rd_valid  out  1  read word available.
- rd_ready  in  1  read word consumed.
- rd_data  out  DATA_WIDTH  read word, right-aligned, zero-extended.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky error for the last command; valid from done until the next command is accepted.
- err_addr  out  ADDR_WIDTH  address of the first access with biu_err = 1.
- biu_strb  out  1  access request to the BIU.
- biu_rw, biu_addr, biu_word_size  out  1 / ADDR_WIDTH / 4  access attributes.
- biu_di  out  DATA_WIDTH  write data to the BIU.
- biu_rdy  in  1  BIU ready; high at idle.
- biu_do  in  DATA_WIDTH  BIU read data.
- biu_err  in  1  BIU error for the completed access.

Behaviour:
- Reset values:
  - cmd_ready = 1; all other outputs = 0, including biu_* outputs, done, err, err_addr, rd_data.
  - State = IDLE.
- FSM states: IDLE, FETCH, ISSUE, WAIT, RDOUT, FIN.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch addr, rw, size, and remaining = cmd_count; clear err and err_addr.
  - Illegal size (not 1/2/4, or 8 with DATA_WIDTH = 32): go to FIN with err = 1 and err_addr = cmd_addr. No BIU access.
  - count = 0: go to FIN with err = 0.
  - Otherwise: write goes to FETCH, read goes to ISSUE.
  - cmd_ready = 0 in every state except IDLE.
- FETCH:
  - wr_ready = 1.
  - On handshake, register biu_di = wr_data << (DATA_WIDTH − 8·size); the BIU consumes the MSB-aligned slice.
  - Go to ISSUE.
- ISSUE:
  - biu_strb = 1, with biu_addr, biu_rw, and biu_word_size from the current registers.
  - Attributes stay stable while biu_strb is high.
  - On biu_strb && biu_rdy: drop biu_strb next cycle and go to WAIT.
  - A strobe is never asserted without a following WAIT (one access outstanding, max).
- WAIT:
  - Exit on the first cycle biu_rdy = 1. The BIU clears rdy on the accept edge, so WAIT never sees a stale high.
  - On exit: if biu_err and err == 0, set err = 1 and err_addr = current addr.
  - addr += size, modulo 2^ADDR_WIDTH (wrap allowed, no error); remaining −= 1.
  - Read: capture rd_data = biu_do, go to RDOUT.
  - Write: go to FETCH if remaining ≠ 0, else FIN.
- RDOUT:
  - rd_valid = 1, rd_data held stable.
  - On rd_ready: go to ISSUE if remaining ≠ 0, else FIN.
- Errors do not abort the burst; all cmd_count accesses are performed.
- FIN: done = 1 for one cycle, then IDLE.
- Throughput: best case 1 + BIU latency + 1 cycles per write; the read-side handshake can overlap with nothing (strictly serial).
- Reset mid-operation:
  - Immediate return to reset values; the pending command is discarded and no done is generated.
  - Any BIU access in flight is left to the BIU, which shares biu_rst.

Test Plan:
- Write burst: cmd_addr = 0x1000, size = 4, count = 3, wr_data 0xA, 0xB, 0xC → three strobes at 0x1000 / 0x1004 / 0x1008 with biu_di = 0xA / 0xB / 0xC and biu_rw = 0 → done, err = 0.
- Byte write: addr = 0x2003, size = 1, wr_data = 0x5A, DATA_WIDTH = 32 → biu_di = 0x5A000000, biu_word_size = 1.
- Read burst with a stalled sink: size = 2, count = 2, biu_do = 0x1234 then 0xBEEF; hold rd_ready = 0 for 5 cycles → rd_data held at 0x1234 with no second strobe until the handshake; done after the second read.
- Error: count = 4, biu_err = 1 on accesses 2 and 4, start 0x0 size 4 → all 4 accesses issued, done with err = 1 and err_addr = 0x4.
- Boundaries:
  - count = 0 → done the cycle after accept, no strobe.
  - size = 3 → done, err = 1, no strobe.
  - addr = 0xFFFFFFFC, count = 2 → second access at 0x00000000.
- Reset asserted in WAIT → outputs return to reset values next edge, cmd_ready = 1, no done pulse.
